// File: rtl/spatial_accumulator_ctrl.sv
// Channel sequencer for the spatial accumulator: walks one frame of channels, drives the
// accumulator controls and holds the result behind a valid/ready pair. Optional macro:
// SPATIAL_CTRL_XOR_FINAL_EN enables the store-second / xor-final weighting outputs.
module spatial_accumulator_ctrl #(
    parameter int unsigned NUM_CHANNELS = 217,
    parameter int unsigned CH_IDX_WIDTH = 8
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    FrameValid_SI,
    output logic                    FrameReady_SO,
    input  logic                    ChannelValid_SI,
    input  logic                    Abort_SI,
    output logic [CH_IDX_WIDTH-1:0] ChannelIdx_DO,
    output logic                    AccEnable_SO,
    output logic                    AccFirst_SO,
    output logic                    AccStoreSecond_SO,
    output logic                    AccXorFinal_SO,
    output logic                    OutValid_SO,
    input  logic                    OutReady_SI
);

    localparam logic [CH_IDX_WIDTH-1:0] LastIdx   = CH_IDX_WIDTH'(NUM_CHANNELS - 1);
    localparam logic [CH_IDX_WIDTH-1:0] SecondIdx = CH_IDX_WIDTH'(1);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    state_e                  state_q, state_d;
    logic [CH_IDX_WIDTH-1:0] idx_q, idx_d;

    logic frame_ready;
    logic frame_hs;
    logic is_last;
    logic acc_en;

    // HOLD with OutReady_SI hands the result over and may accept the next frame in one cycle.
    assign frame_ready = (state_q == StIdle) | ((state_q == StHold) & OutReady_SI);
    assign frame_hs    = FrameValid_SI & frame_ready;
    assign is_last     = (idx_q == LastIdx);

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (frame_hs) begin
                    state_d = StAccum;
                    idx_d   = '0;
                end
            end
            StAccum: begin
                if (Abort_SI) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else if (ChannelValid_SI) begin
                    if (is_last) begin
                        state_d = StHold;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + SecondIdx;
                    end
                end
            end
            StHold: begin
                if (OutReady_SI) begin
                    state_d = frame_hs ? StAccum : StIdle;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        acc_en            = (state_q == StAccum) & ChannelValid_SI & ~Abort_SI;
        FrameReady_SO     = frame_ready;
        OutValid_SO       = (state_q == StHold);
        ChannelIdx_DO     = idx_q;
        AccEnable_SO      = acc_en;
        AccFirst_SO       = acc_en & (idx_q == '0);
`ifdef SPATIAL_CTRL_XOR_FINAL_EN
        AccStoreSecond_SO = acc_en & (idx_q == SecondIdx);
        AccXorFinal_SO    = acc_en & is_last;
`else
        AccStoreSecond_SO = 1'b0;
        AccXorFinal_SO    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_spatial_accumulator_ctrl.sv
// Scoreboard bench for spatial_accumulator_ctrl with a 4-channel frame: full rate, stalls,
// backpressure/handover, abort and asynchronous reset.
module tb_spatial_accumulator_ctrl;

    localparam int unsigned NCh = 4;
    localparam int unsigned W   = 8;

    logic         clk;
    logic         rst;
    logic         frame_valid, frame_ready, ch_valid, abort_in, out_valid, out_ready;
    logic [W-1:0] ch_idx;
    logic         acc_en, acc_first, acc_second, acc_xor;

    typedef struct packed {
        int         cyc;
        logic [W-1:0] idx;
        logic [5:0] ctl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_no   = 0;

    spatial_accumulator_ctrl #(
        .NUM_CHANNELS(NCh),
        .CH_IDX_WIDTH(W)
    ) dut (
        .Clk_CI           (clk),
        .Reset_RI         (rst),
        .FrameValid_SI    (frame_valid),
        .FrameReady_SO    (frame_ready),
        .ChannelValid_SI  (ch_valid),
        .Abort_SI         (abort_in),
        .ChannelIdx_DO    (ch_idx),
        .AccEnable_SO     (acc_en),
        .AccFirst_SO      (acc_first),
        .AccStoreSecond_SO(acc_second),
        .AccXorFinal_SO   (acc_xor),
        .OutValid_SO      (out_valid),
        .OutReady_SI      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [5:0] dut_ctl();
        return {acc_en, acc_first, acc_second, acc_xor, out_valid, frame_ready};
    endfunction

    // Drive one cycle of inputs and queue the outputs the spec requires for that cycle.
    task automatic cyc(input logic fv, input logic cv, input logic ab, input logic ordy,
                       input int e_idx, input logic e_en, input logic e_fr, input logic e_ov);
        exp_t e;
        logic sec, xr;
        @(negedge clk);
        cyc_no++;
        frame_valid = fv;
        ch_valid    = cv;
        abort_in    = ab;
        out_ready   = ordy;
`ifdef SPATIAL_CTRL_XOR_FINAL_EN
        sec = e_en && (e_idx == 1);
        xr  = e_en && (e_idx == NCh - 1);
`else
        sec = 1'b0;
        xr  = 1'b0;
`endif
        e.cyc = cyc_no;
        e.idx = W'(e_idx);
        e.ctl = {e_en, e_en && (e_idx == 0), sec, xr, e_ov, e_fr};
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq($sformatf("idx@%0d", e.cyc), 32'(ch_idx), 32'(e.idx));
            check_eq($sformatf("ctl@%0d", e.cyc), 32'(dut_ctl()), 32'(e.ctl));
        end
    end

    initial begin
        rst         = 1'b1;
        frame_valid = 1'b0;
        ch_valid    = 1'b0;
        abort_in    = 1'b0;
        out_ready   = 1'b0;
        #2;
        check_eq("rst_idx", 32'(ch_idx), 32'd0);
        check_eq("rst_ctl", 32'(dut_ctl()), 32'b000001);
        @(negedge clk);
        rst = 1'b0;

        //   fv cv ab rdy idx en fr ov
        cyc(1, 1, 0, 0, 0, 0, 1, 0);  // full-rate frame accepted
        cyc(0, 1, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 2, 1, 0, 0);
        cyc(0, 1, 0, 0, 3, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 1);  // HOLD, backpressured for 3 cycles
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 1, 0, 0, 1, 1);  // handover: consume + accept
        cyc(0, 1, 0, 0, 0, 1, 0, 0);  // stalled frame
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 2, 1, 0, 0);
        cyc(0, 0, 0, 0, 3, 0, 0, 0);
        cyc(0, 1, 0, 0, 3, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 1, 1);  // consume, back to IDLE
        cyc(1, 0, 0, 0, 0, 0, 1, 0);  // frame to be aborted
        cyc(0, 1, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 2, 0, 0, 0);  // abort at idx 2
        cyc(0, 1, 1, 0, 0, 0, 1, 0);  // IDLE, abort ignored
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 2, 1, 0, 0);
        cyc(0, 1, 0, 0, 3, 1, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 1);  // abort ignored in HOLD
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 1, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 2, 1, 0, 0);

        // Asynchronous reset in the middle of an ACCUM cycle.
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_idx", 32'(ch_idx), 32'd0);
        check_eq("arst_ctl", 32'(dut_ctl()), 32'b000001);
        @(negedge clk);
        rst      = 1'b0;
        ch_valid = 1'b0;
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        @(negedge clk);
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spatial_accumulator_ctrl.md
# spatial_accumulator_ctrl

Sequencer for the spatial accumulator. Steps through the channels of one modality frame, gates the accumulator's enable, and drives its first / store-second / xor-final controls. It also emits the channel index used to address the feature buffer and the item/projection memories. A valid/ready pair toward the temporal stage holds the majority hypervector until the downstream stage consumes it.

## Interface
- NUM_CHANNELS, 217: channels per modality frame; legal range 3..2^CH_IDX_WIDTH.
- CH_IDX_WIDTH, 8: width of the channel index.
- Clk_CI  input  1  clock, rising edge.
- Reset_RI  input  1  reset; asynchronous, active-high.
- FrameValid_SI  input  1  new frame available in the feature buffer.
- FrameReady_SO  output  1  frame accepted this cycle when high together with FrameValid_SI.
- ChannelValid_SI  input  1  feature and item-memory data for ChannelIdx_DO are valid this cycle.
- Abort_SI  input  1  synchronous abort of the frame in progress.
- ChannelIdx_DO  output  CH_IDX_WIDTH  current channel address.
- AccEnable_SO  output  1  to accumulator Enable_SI.
- AccFirst_SO  output  1  to FirstHypervector_SI.
- AccStoreSecond_SO  output  1  to store_second.
- AccXorFinal_SO  output  1  to xor_final.
- OutValid_SO  output  1  accumulator output HypervectorOut_DO is a complete frame result.
- OutReady_SI  input  1  downstream consumes the result.

## Operation
- States: IDLE, ACCUM, HOLD. Reset state is IDLE.
- Reset values: ChannelIdx_DO=0, OutValid_SO=0, FrameReady_SO=1. All Acc* outputs are 0.
- FrameReady_SO = (state==IDLE) | (state==HOLD & OutReady_SI).
- On a frame handshake (FrameValid_SI & FrameReady_SO):
  - next state is ACCUM and ChannelIdx_DO is set to 0.
  - from HOLD, the output is consumed and the new frame accepted in the same cycle.
- ACCUM is the only state in which the accumulator is enabled:
  - AccEnable_SO = ChannelValid_SI.
  - AccFirst_SO = AccEnable_SO & (idx==0).
  - AccStoreSecond_SO = AccEnable_SO & (idx==1).
  - AccXorFinal_SO = AccEnable_SO & (idx==NUM_CHANNELS-1).
  - All Acc* outputs are combinational from the registered state/idx and ChannelValid_SI.
- Channel advance in ACCUM: ChannelIdx_DO increments on each cycle with ChannelValid_SI=1. With ChannelValid_SI=0, the index holds and nothing is accumulated (stall).
- Last channel: on the enabled cycle at idx==NUM_CHANNELS-1, next state is HOLD and idx wraps to 0.
- HOLD:
  - OutValid_SO=1 and all Acc* outputs are 0, so the accumulator value is frozen.
  - OutReady_SI=1 & FrameValid_SI=0: go to IDLE.
  - OutReady_SI=1 & FrameValid_SI=1: go to ACCUM.
  - OutReady_SI=0: stay in HOLD; ChannelValid_SI is ignored.
- Abort_SI:
  - In ACCUM it has priority over the channel advance: go to IDLE, idx=0, and AccEnable_SO is forced to 0 that cycle.
  - In IDLE and HOLD it is ignored; a completed result is never discarded.
- No accumulator clear is required between frames: AccFirst_SO on channel 0 overwrites it.

## Timing
- Channel k is accumulated at the rising edge closing the cycle in which idx==k and ChannelValid_SI=1.
- Full-rate frame: NUM_CHANNELS cycles in ACCUM. OutValid_SO rises the cycle after the last channel edge, which is when the accumulator register holds the final sum.
- Minimum frame period: NUM_CHANNELS+1 cycles, using back-to-back HOLD→ACCUM handover.
- Asynchronous reset mid-frame: state, idx and OutValid return to reset values immediately. Acc* outputs drop to 0 combinationally.

## Configuration
- SPATIAL_CTRL_XOR_FINAL_EN defined: AccStoreSecond_SO and AccXorFinal_SO behave as above, giving second-channel/final-channel XOR weighting.
- SPATIAL_CTRL_XOR_FINAL_EN undefined: both outputs are tied to 0. The accumulator then does plain per-channel counting, and all other behaviour is identical.

## Test plan
- Bench settings: NUM_CHANNELS=4, macro defined.
- Full rate: FrameValid at cycle 0, ChannelValid held 1 → idx 0,1,2,3 on cycles 1–4; AccFirst on cycle 1, AccStoreSecond on cycle 2, AccXorFinal on cycle 4; OutValid=1 from cycle 5.
- Stalls: ChannelValid=0 on the cycles where idx==1 and idx==3 first appear → idx holds, AccEnable=0 on those cycles; OutValid rises 2 cycles later than full rate.
- Backpressure / handover: OutReady=0 for 3 cycles in HOLD → OutValid stays 1 and AccEnable stays 0. Then OutReady=1 with FrameValid=1 → FrameReady=1 that cycle and idx=0 in ACCUM the next cycle.
- Abort at idx==2 → AccEnable=0 that cycle, IDLE next cycle, no OutValid. The following frame starts with AccFirst at idx 0.
- Asynchronous reset asserted mid-cycle during ACCUM → outputs return to reset values before the next edge. Rebuild with the macro undefined → AccStoreSecond and AccXorFinal are never 1 across a full frame.
